// File: rtl/lj_force_pipe.sv
// Streaming Lennard-Jones force accumulator: 5 register stages, last beat to out_valid in 5 cycles.
// Backpressure: a result held without out_ready freezes every stage; in_ready = !(out_valid && !out_ready).
module lj_force_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                FRAC_W   = 16,
  parameter int                TBL_AW   = 8,
  parameter int                R2_SHIFT = 12,
  parameter logic [DATA_W-1:0] CUTOFF2  = 32'h0009_0000,
  parameter int                CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DATA_W-1:0]   in_ref,
  input  logic [3*DATA_W-1:0]   in_nbr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*DATA_W-1:0]   out_force,
  output logic [CNT_W-1:0]      out_count,
  input  logic                  tbl_we,
  input  logic [TBL_AW-1:0]     tbl_addr,
  input  logic [DATA_W-1:0]     tbl_data
);
  localparam int TBL_N = 1 << TBL_AW;
  localparam int PW    = 2 * DATA_W;
  localparam int SW    = 2 * DATA_W + 2;
  localparam logic [SW-1:0] SAT_TH = SW'(1) << (DATA_W + FRAC_W);

  typedef logic [2:0][DATA_W-1:0] vec_t;

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = s[DATA_W-1:0];
  endfunction

  // S1: displacement
  logic s1_vld, s1_last;
  vec_t s1_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_d    <= '0;
    end else if (en) begin
      s1_vld  <= in_valid;
      s1_last <= in_valid && in_last;
      for (int i = 0; i < 3; i++)
        s1_d[i] <= in_ref[i*DATA_W +: DATA_W] - in_nbr[i*DATA_W +: DATA_W];
    end
  end

  // S2: squared distance, full-width then saturated
  logic signed [PW-1:0] sq [3];
  logic [SW-1:0]        sq_sum;
  logic [DATA_W-1:0]    r2_sat;
  always_comb begin
    for (int i = 0; i < 3; i++)
      sq[i] = $signed({{DATA_W{s1_d[i][DATA_W-1]}}, s1_d[i]})
            * $signed({{DATA_W{s1_d[i][DATA_W-1]}}, s1_d[i]});
    sq_sum = {2'b00, sq[0]} + {2'b00, sq[1]} + {2'b00, sq[2]};
    r2_sat = (sq_sum >= SAT_TH) ? '1 : DATA_W'(sq_sum >> FRAC_W);
  end

  logic s2_vld, s2_last;
  vec_t s2_d;
  logic [DATA_W-1:0] s2_r2;
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_d    <= '0;
      s2_r2   <= '0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_d    <= s1_d;
      s2_r2   <= r2_sat;
    end
  end

  // S3: cutoff test and table lookup; the table itself is never reset
  logic [DATA_W-1:0] tbl [TBL_N];
  logic [DATA_W-1:0] idx_full;
  logic [TBL_AW-1:0] tbl_idx;
  logic              in_cut;
  always_comb begin
    idx_full = s2_r2 >> R2_SHIFT;
    tbl_idx  = (idx_full > DATA_W'(TBL_N - 1)) ? TBL_AW'(TBL_N - 1) : idx_full[TBL_AW-1:0];
    in_cut   = (s2_r2 != '0) && (s2_r2 < CUTOFF2);
  end

  always_ff @(posedge clk) begin
    if (tbl_we)
      tbl[tbl_addr] <= tbl_data;
  end

  logic s3_vld, s3_last, s3_in;
  vec_t s3_d;
  logic [DATA_W-1:0] s3_t;
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      s3_in   <= 1'b0;
      s3_d    <= '0;
      s3_t    <= '0;
    end else if (en) begin
      s3_vld  <= s2_vld;
      s3_last <= s2_last;
      s3_in   <= in_cut;
      s3_d    <= s2_d;
      s3_t    <= tbl[tbl_idx];
    end
  end

  // S4: scale displacement by F(r)/r
  logic [DATA_W-1:0] f_nxt [3];
  always_comb begin
    for (int i = 0; i < 3; i++)
      f_nxt[i] = DATA_W'(($signed({{DATA_W{s3_t[DATA_W-1]}}, s3_t})
                        * $signed({{DATA_W{s3_d[i][DATA_W-1]}}, s3_d[i]})) >>> FRAC_W);
  end

  logic s4_vld, s4_last, s4_in;
  vec_t s4_f;
  always_ff @(posedge clk) begin
    if (rst) begin
      s4_vld  <= 1'b0;
      s4_last <= 1'b0;
      s4_in   <= 1'b0;
      s4_f    <= '0;
    end else if (en) begin
      s4_vld  <= s3_vld;
      s4_last <= s3_last;
      s4_in   <= s3_in;
      for (int i = 0; i < 3; i++)
        s4_f[i] <= s3_in ? f_nxt[i] : '0;
    end
  end

  // S5: saturating accumulate; a last beat hands its sums to the output and restarts at zero
  vec_t             acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  always_comb begin
    for (int i = 0; i < 3; i++)
      acc_nxt[i] = sat_add(acc[i], s4_f[i]);
    cnt_nxt = (s4_in && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_force <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (en && s4_vld) begin
        if (s4_last) begin
          out_force <= acc_nxt;
          out_count <= cnt_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_lj_force_pipe.sv
// Scoreboard bench for lj_force_pipe: directed cases with hand-derived results plus a
// randomized phase checked against a plain-arithmetic reference model.
module tb_lj_force_pipe;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [95:0] in_ref, in_nbr, out_force;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_count;
  logic        tbl_we;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;

  lj_force_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ref(in_ref), .in_nbr(in_nbr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_force(out_force), .out_count(out_count),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
  );

  typedef struct {
    logic [95:0] f;
    logic [15:0] c;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          rdy_mode = 1;
  logic [31:0] tb_tbl [256];
  longint      m_acc [3];
  int          m_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready moves just after the rising edge: 0 = held low, 1 = high, 2 = random
  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = (rdy_mode == 1);
  end

  // Monitor
  bit          m_fresh = 1'b1;
  bit          m_held  = 1'b0;
  logic [95:0] m_hf;
  logic [15:0] m_hc;
  int          m_first = 0;
  exp_t        m_e;
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (m_fresh) begin m_first = cyc; m_fresh = 1'b0; end
      if (m_held) begin
        checks++;
        if (out_force !== m_hf || out_count !== m_hc) begin
          errors++;
          $display("FAIL hold: force=%h count=%0d changed while stalled, expected force=%h count=%0d",
                   out_force, out_count, m_hf, m_hc);
        end
      end
      if (out_ready === 1'b0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: in_ready=%b while result held, expected 0", in_ready);
        end
        m_held = 1'b1; m_hf = out_force; m_hc = out_count;
      end else begin
        m_held = 1'b0; m_fresh = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: force=%h count=%0d, expected no output", out_force, out_count);
        end else begin
          m_e = exp_q.pop_front();
          if (out_force !== m_e.f || out_count !== m_e.c) begin
            errors++;
            $display("FAIL result: force=%h count=%0d, expected force=%h count=%0d",
                     out_force, out_count, m_e.f, m_e.c);
          end
          if (m_e.lat) begin
            checks++;
            if (m_first - m_e.acc_cyc != 5) begin
              errors++;
              $display("FAIL latency: got %0d cycles, expected 5", m_first - m_e.acc_cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic logic [31:0] rc();
    return 32'($urandom_range(0, 32'h40000)) - 32'h20000;
  endfunction

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_addr = 8'(a); tbl_data = d; tb_tbl[a] = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [95:0] r, input logic [95:0] n, input bit last);
    int g;
    in_ref = r; in_nbr = n; in_last = last; in_valid = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected it to rise", g);
    end
    last_acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input logic [95:0] f, input logic [15:0] c, input bit lat);
    exp_t e;
    e.f = f; e.c = c; e.acc_cyc = last_acc_cyc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference model: per-pair force from the table rules, clamped running sums per reference
  task automatic model_beat(input logic [95:0] r, input logic [95:0] n, input bit last);
    logic signed [31:0] d [3];
    logic signed [31:0] t;
    logic [31:0]        f;
    longint             s, r2;
    int                 idx;
    bit                 hit;
    s = 0;
    for (int a = 0; a < 3; a++) begin
      d[a] = r[a*32 +: 32] - n[a*32 +: 32];
      s += longint'(d[a]) * longint'(d[a]);
    end
    r2 = s >>> 16;
    if (r2 > 64'sh0_FFFF_FFFF) r2 = 64'sh0_FFFF_FFFF;
    hit = (r2 != 0) && (r2 < 64'sh9_0000);
    idx = ((r2 >>> 12) > 255) ? 255 : int'(r2 >>> 12);
    t = tb_tbl[idx];
    for (int a = 0; a < 3; a++)
      if (hit) begin
        f = 32'((longint'(t) * longint'(d[a])) >>> 16);
        m_acc[a] = sat32(m_acc[a] + longint'($signed(f)));
      end
    if (hit && m_cnt < 65535) m_cnt++;
    send(r, n, last);
    if (last) begin
      push({32'(m_acc[2]), 32'(m_acc[1]), 32'(m_acc[0])}, 16'(m_cnt), 1'b0);
      m_acc = '{0, 0, 0};
      m_cnt = 0;
    end
  endtask

  int          g2, nb;
  logic [95:0] rr, nn;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_ref = '0; in_nbr = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++; if (out_force !== 96'd0) begin errors++; $display("FAIL reset_out_force: got %h, expected 0", out_force); end
    checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL reset_out_count: got %0d, expected 0", out_count); end

    // Single pair: F/r=2.0, dx=1.0 -> fx=2.0
    wr(16, 32'h0002_0000);
    send(v3(32'h0002_0000, 0, 0), v3(ONE, 0, 0), 1'b1);
    push(v3(32'h0002_0000, 0, 0), 16'd1, 1'b1);
    drain();

    // Cutoff boundary (r2 == 9.0) and self-pair both excluded
    send(v3(0, 0, 0), v3(32'h0003_0000, 0, 0), 1'b0);
    send(v3(0, 0, 0), v3(0, 0, 0), 1'b1);
    push(96'd0, 16'd0, 1'b0);
    drain();

    // Accumulation over three back-to-back neighbors
    wr(16, ONE);
    send(v3(0, 0, 0), v3(-ONE, 0, 0), 1'b0);
    send(v3(0, 0, 0), v3(0, -ONE, 0), 1'b0);
    send(v3(0, 0, 0), v3(0, 0, -ONE), 1'b1);
    push(v3(ONE, ONE, ONE), 16'd3, 1'b1);
    drain();

    // Back-pressure: two references, out_ready held low 10 cycles after the first result
    wr(64, 32'hFFFF_8000);
    rdy_mode = 0;
    @(negedge clk);
    fork
      begin
        send(v3(32'h0002_0000, 0, 0), v3(ONE, 0, 0), 1'b1);
        push(v3(ONE, 0, 0), 16'd1, 1'b1);
        send(v3(0, 0, 0), v3(0, 32'h0002_0000, 0), 1'b0);
        send(v3(0, 0, 0), v3(0, 0, ONE), 1'b1);
        push(v3(0, ONE, 32'hFFFF_0000), 16'd2, 1'b0);
      end
      begin
        g2 = 0;
        while (out_valid !== 1'b1 && g2 < 200) begin @(negedge clk); g2++; end
        repeat (10) @(negedge clk);
        rdy_mode = 1;
      end
    join
    drain();

    // Saturation, positive then negative
    wr(16, 32'h7FFF_0000);
    for (int i = 0; i < 40; i++) send(v3(ONE, 0, 0), v3(0, 0, 0), i == 39);
    push(v3(32'h7FFF_FFFF, 0, 0), 16'd40, 1'b0);
    for (int i = 0; i < 3; i++) send(v3(0, 0, 0), v3(ONE, 0, 0), i == 2);
    push(v3(32'h8000_0000, 0, 0), 16'd3, 1'b0);
    drain();

    // Reset after 2 of 3 beats discards the partial reference
    wr(16, 32'h0002_0000);
    send(v3(32'h0002_0000, 0, 0), v3(ONE, 0, 0), 1'b0);
    send(v3(32'h0002_0000, 0, 0), v3(ONE, 0, 0), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_flush: out_valid=%b, expected 0", out_valid); end
    send(v3(32'h0002_0000, 0, 0), v3(ONE, 0, 0), 1'b1);
    push(v3(32'h0002_0000, 0, 0), 16'd1, 1'b1);
    drain();

    // Randomized references with random downstream readiness
    for (int a = 0; a < 256; a++) wr(a, 32'($urandom_range(0, 32'h20_0000)) - 32'h10_0000);
    m_acc = '{0, 0, 0};
    m_cnt = 0;
    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      nb = $urandom_range(1, 6);
      rr = v3(rc(), rc(), rc());
      for (int j = 0; j < nb; j++) begin
        nn = ($urandom_range(0, 7) == 0) ? rr : v3(rc(), rc(), rc());
        model_beat(rr, nn, j == nb - 1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    rdy_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
